// File: rtl/_bus_arbiter.sv
// rtl/_bus_arbiter.sv - registered round-robin arbiter driving active-low _bus32 enables
// Grants at most one source and inserts TURN all-disabled cycles between grants.
module _bus_arbiter #(
   parameter int N        = 8,
   parameter int TURN     = 1,
   parameter int MAX_HOLD = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         g,
   output logic [N-1:0]         gnt_oh,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 bus_busy
);
   localparam int IW = $clog2(N);
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int TW = $clog2(TURN + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] ptr, ptr_nxt, idx_nxt, win, cand;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic [TW-1:0] turn_cnt, turn_nxt;
   logic [N-1:0]  g_nxt;
   logic          found, hold_ok, arb;

   // Scan downward so the requester closest to ptr is the last one written.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         cand = IW'((int'(ptr) + i) % N);
         if (req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign hold_ok = (MAX_HOLD == 0) || (int'(hold_cnt) < MAX_HOLD - 1);

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      hold_nxt  = hold_cnt;
      turn_nxt  = turn_cnt;
      g_nxt     = g;
      idx_nxt   = gnt_idx;
      arb       = 1'b0;
      case (state)
         ST_GRANT: begin
            if (req[gnt_idx] && hold_ok) begin
               hold_nxt = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
            end else begin
               g_nxt     = '1;
               idx_nxt   = '0;
               ptr_nxt   = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
               hold_nxt  = '0;
               turn_nxt  = TW'(TURN - 1);
               state_nxt = ST_TURN;
            end
         end
         ST_TURN: begin
            if (turn_cnt != '0) turn_nxt = turn_cnt - 1'b1;
            else                arb      = 1'b1;
         end
         default: arb = 1'b1;
      endcase
      if (arb) begin
         hold_nxt = '0;
         if (found) begin
            g_nxt     = ~({{(N-1){1'b0}}, 1'b1} << win);
            idx_nxt   = win;
            state_nxt = ST_GRANT;
         end else begin
            g_nxt     = '1;
            idx_nxt   = '0;
            state_nxt = ST_IDLE;
         end
      end
   end

   // Every output is its own flop so nothing combinational reaches _bus32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         turn_cnt <= '0;
         g        <= '1;
         gnt_oh   <= '0;
         gnt_idx  <= '0;
         bus_busy <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         hold_cnt <= hold_nxt;
         turn_cnt <= turn_nxt;
         g        <= g_nxt;
         gnt_oh   <= ~g_nxt;
         gnt_idx  <= idx_nxt;
         bus_busy <= ~&g_nxt;
      end
   end
endmodule

// File: tb/tb__bus_arbiter.sv
// tb/tb__bus_arbiter.sv - self-checking bench for _bus_arbiter
// Three instances: (TURN=1,MAX_HOLD=4), (TURN=1,MAX_HOLD=2), (TURN=3,MAX_HOLD=0).
module tb__bus_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_v  [3];
   logic [3:0] g_v    [3];
   logic [3:0] oh_v   [3];
   logic [1:0] idx_v  [3];
   logic       busy_v [3];

   int n_pass  = 0;
   int n_total = 0;

   int mh [3] = '{4, 2, 0};
   int tn [3] = '{1, 1, 3};
   int m_owner [3];
   int m_held  [3];
   int m_gap   [3];
   int m_ptr   [3];

   _bus_arbiter #(.N(4), .TURN(1), .MAX_HOLD(4)) dut_a (
      .clk(clk), .rst(rst), .req(req_v[0]), .g(g_v[0]), .gnt_oh(oh_v[0]),
      .gnt_idx(idx_v[0]), .bus_busy(busy_v[0]));
   _bus_arbiter #(.N(4), .TURN(1), .MAX_HOLD(2)) dut_b (
      .clk(clk), .rst(rst), .req(req_v[1]), .g(g_v[1]), .gnt_oh(oh_v[1]),
      .gnt_idx(idx_v[1]), .bus_busy(busy_v[1]));
   _bus_arbiter #(.N(4), .TURN(3), .MAX_HOLD(0)) dut_c (
      .clk(clk), .rst(rst), .req(req_v[2]), .g(g_v[2]), .gnt_oh(oh_v[2]),
      .gnt_idx(idx_v[2]), .bus_busy(busy_v[2]));

   always #5 clk = ~clk;

   task automatic cycle;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_init;
      for (int d = 0; d < 3; d++) begin
         m_owner[d] = -1;
         m_held[d]  = 0;
         m_gap[d]   = 0;
         m_ptr[d]   = 0;
      end
   endtask

   // One clock edge of the arbiter rules: owner held cycles, idle gap left, rotating pointer.
   task automatic model_step(input int d, input logic [3:0] r);
      if (m_owner[d] >= 0) begin
         if (!r[m_owner[d]] || (mh[d] != 0 && m_held[d] >= mh[d])) begin
            m_ptr[d]   = (m_owner[d] + 1) % 4;
            m_owner[d] = -1;
            m_gap[d]   = tn[d];
         end else begin
            m_held[d]++;
         end
      end else if (m_gap[d] > 1) begin
         m_gap[d]--;
      end else begin
         m_gap[d] = 0;
         for (int off = 0; off < 4; off++) begin
            if (m_owner[d] < 0 && r[(m_ptr[d] + off) % 4]) begin
               m_owner[d] = (m_ptr[d] + off) % 4;
               m_held[d]  = 1;
            end
         end
      end
   endtask

   task automatic do_reset;
      for (int d = 0; d < 3; d++) req_v[d] = 4'b0000;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_init();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      for (int d = 0; d < 3; d++) req_v[d] = 4'b1111;
      cycle();
      for (int d = 0; d < 3; d++) begin
         n_total++;
         if ({g_v[d], oh_v[d], idx_v[d], busy_v[d]} !== {4'b1111, 4'b0000, 2'd0, 1'b0})
            $display("FAIL reset_hold dut%0d: g=%b oh=%b idx=%0d busy=%b expected g=1111 oh=0000 idx=0 busy=0",
                     d, g_v[d], oh_v[d], idx_v[d], busy_v[d]);
         else n_pass++;
      end
      rst = 1'b0;
      cycle();
      n_total++;
      if (g_v[0] !== 4'b1110) $display("FAIL reset_release: g=%b expected 1110", g_v[0]);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_total++;
      if ({g_v[0], busy_v[0]} !== {4'b1111, 1'b0})
         $display("FAIL reset_async: g=%b busy=%b expected g=1111 busy=0", g_v[0], busy_v[0]);
      else n_pass++;
      @(negedge clk);
      for (int d = 0; d < 3; d++) req_v[d] = 4'b0000;
      rst = 1'b0;
      model_init();
   endtask

   task automatic test_single;
      do_reset();
      req_v[0] = 4'b0100;
      cycle();
      n_total++;
      if ({g_v[0], oh_v[0], idx_v[0], busy_v[0]} !== {4'b1011, 4'b0100, 2'd2, 1'b1})
         $display("FAIL single_grant: g=%b oh=%b idx=%0d busy=%b expected g=1011 oh=0100 idx=2 busy=1",
                  g_v[0], oh_v[0], idx_v[0], busy_v[0]);
      else n_pass++;
      cycle();
      n_total++;
      if (g_v[0] !== 4'b1011) $display("FAIL single_hold: g=%b expected 1011", g_v[0]);
      else n_pass++;
      req_v[0] = 4'b0000;
      cycle();
      n_total++;
      if ({g_v[0], idx_v[0], busy_v[0]} !== {4'b1111, 2'd0, 1'b0})
         $display("FAIL single_release: g=%b idx=%0d busy=%b expected g=1111 idx=0 busy=0",
                  g_v[0], idx_v[0], busy_v[0]);
      else n_pass++;
   endtask

   task automatic test_round_robin;
      logic [3:0] eg;
      do_reset();
      req_v[0] = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         cycle();
         eg = ~(4'b0001 << (i % 4));
         n_total++;
         if ({g_v[0], idx_v[0]} !== {eg, 2'(i % 4)})
            $display("FAIL rr_grant %0d: g=%b idx=%0d expected g=%b idx=%0d", i, g_v[0], idx_v[0], eg, i % 4);
         else n_pass++;
         req_v[0][i % 4] = 1'b0;
         if (i == 3) req_v[0][0] = 1'b1;
         cycle();
         n_total++;
         if (g_v[0] !== 4'b1111) $display("FAIL rr_gap %0d: g=%b expected 1111", i, g_v[0]);
         else n_pass++;
      end
   endtask

   task automatic test_hold_limit;
      int seq [11] = '{0, 0, 0, 0, -1, 1, 1, 1, 1, -1, 0};
      logic [3:0] eg;
      do_reset();
      req_v[0] = 4'b0011;
      for (int i = 0; i < 11; i++) begin
         cycle();
         eg = (seq[i] < 0) ? 4'b1111 : ~(4'b0001 << seq[i]);
         n_total++;
         if (g_v[0] !== eg) $display("FAIL hold_limit cycle %0d: g=%b expected %b", i, g_v[0], eg);
         else n_pass++;
      end
      req_v[0] = 4'b0000;
   endtask

   task automatic test_sole_wrap;
      int seq [6] = '{3, 3, -1, 3, 3, -1};
      logic [3:0] eg;
      do_reset();
      req_v[1] = 4'b1000;
      for (int i = 0; i < 6; i++) begin
         cycle();
         eg = (seq[i] < 0) ? 4'b1111 : ~(4'b0001 << seq[i]);
         n_total++;
         if (g_v[1] !== eg) $display("FAIL sole cycle %0d: g=%b expected %b", i, g_v[1], eg);
         else n_pass++;
      end
      req_v[1] = 4'b1001;
      cycle();
      n_total++;
      if ({g_v[1], idx_v[1]} !== {4'b1110, 2'd0})
         $display("FAIL ptr_wrap: g=%b idx=%0d expected g=1110 idx=0", g_v[1], idx_v[1]);
      else n_pass++;
      req_v[1] = 4'b0000;
   endtask

   task automatic test_turn;
      logic [3:0] eg;
      do_reset();
      req_v[2] = 4'b0010;
      repeat (20) cycle();
      n_total++;
      if (g_v[2] !== 4'b1101) $display("FAIL turn_unlimited_hold: g=%b expected 1101", g_v[2]);
      else n_pass++;
      req_v[2] = 4'b0000;
      for (int t = 0; t < 6; t++) begin
         cycle();
         n_total++;
         if (g_v[2] !== 4'b1111) $display("FAIL turn_lost_pulse t%0d: g=%b expected 1111", t, g_v[2]);
         else n_pass++;
         req_v[2] = (t == 0) ? 4'b0100 : 4'b0000;
      end
      req_v[2] = 4'b0010;
      cycle();
      n_total++;
      if (g_v[2] !== 4'b1101) $display("FAIL turn_regrant: g=%b expected 1101", g_v[2]);
      else n_pass++;
      req_v[2] = 4'b0001;
      for (int t = 0; t < 4; t++) begin
         cycle();
         eg = (t < 3) ? 4'b1111 : 4'b1110;
         n_total++;
         if (g_v[2] !== eg) $display("FAIL turn_gap t%0d: g=%b expected %b", t, g_v[2], eg);
         else n_pass++;
      end
      req_v[2] = 4'b0000;
   endtask

   task automatic test_random;
      logic [3:0] eg, mask;
      logic [1:0] ei;
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         for (int d = 0; d < 3; d++) begin
            mask = '0;
            for (int b = 0; b < 4; b++) mask[b] = ($urandom_range(3) == 0);
            req_v[d] = req_v[d] ^ mask;
            model_step(d, req_v[d]);
         end
         cycle();
         for (int d = 0; d < 3; d++) begin
            eg = (m_owner[d] < 0) ? 4'b1111 : ~(4'b0001 << m_owner[d]);
            ei = (m_owner[d] < 0) ? 2'd0 : 2'(m_owner[d]);
            n_total++;
            if ({g_v[d], oh_v[d], idx_v[d], busy_v[d]} !== {eg, ~eg, ei, (m_owner[d] >= 0)})
               $display("FAIL random dut%0d cycle %0d: g=%b oh=%b idx=%0d busy=%b expected g=%b oh=%b idx=%0d busy=%b",
                        d, c, g_v[d], oh_v[d], idx_v[d], busy_v[d], eg, ~eg, ei, (m_owner[d] >= 0));
            else n_pass++;
            n_total++;
            if ($countones(~g_v[d]) > 1)
               $display("FAIL onehot dut%0d cycle %0d: g=%b expected at most one low bit", d, c, g_v[d]);
            else n_pass++;
         end
      end
      for (int d = 0; d < 3; d++) req_v[d] = 4'b0000;
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 3; d++) req_v[d] = 4'b0000;
      model_init();
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_hold_limit();
      test_sole_wrap();
      test_turn();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
